tile_loader: RTL and testbench

//  Loads one 32x32 tile from the DDR3 framebuffer into the tile buffer BRAM, so shading can

---
 rtl/tile_pkg.sv | 58 +++++
 rtl/tile_row_fifo.sv | 73 +++++++
 rtl/tile_loader.sv | 197 +++++++++++++++++++
 tb/tb_tile_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// -----------------------------------------------------------------------------
// tile_pkg
//   Shared constants and helpers for the tile loader:
//     - tile geometry (TILE_W x TILE_H), framebuffer base and row stride
//       (both in DDRAM 64-bit words)
//     - row FIFO depth and the burst length used per tile row
//     - FSM state type
//     - the u0.10 pixel struct and the ARGB8888 -> u0.10 conversion
//   Optional feature macro: TILE_LOADER_ALPHA_EN
//     defined     : alpha is taken from byte 3 and converted like a colour channel
//     not defined : byte 3 is ignored and alpha is forced to 1.0 (16'h03FF)
// -----------------------------------------------------------------------------
package tile_pkg;

   localparam int          TILE_W       = 32;
   localparam int          TILE_H       = 32;
   localparam logic [28:0] FB_BASE      = 29'h06000000;
   localparam int          STRIDE_WORDS = 320;
   localparam int          FIFO_DEPTH   = 32;
   // Two ARGB8888 pixels per 64-bit word, so one row is TILE_W/2 words.
   localparam int          BURST_LEN    = TILE_W / 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RECV,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] g;
      logic [15:0] r;
   } px_u010_t;

   // Replicating the top two bits into the LSBs maps 0x00->0x000 and
   // 0xFF->0x3FF exactly.
   function automatic logic [15:0] chan8_to_u010(input logic [7:0] c);
      return {6'b0, c, c[7:6]};
   endfunction

   // Input pixel layout is 0xAABBGGRR.
   function automatic px_u010_t argb8_to_u010(input logic [31:0] p);
      px_u010_t px;
      px.r = chan8_to_u010(p[7:0]);
      px.g = chan8_to_u010(p[15:8]);
      px.b = chan8_to_u010(p[23:16]);
`ifdef TILE_LOADER_ALPHA_EN
      px.a = chan8_to_u010(p[31:24]);
`else
      px.a = 16'h03FF;
`endif
      return px;
   endfunction

endpackage

// File: rtl/tile_row_fifo.sv
// -----------------------------------------------------------------------------
// tile_row_fifo
//   Synchronous show-ahead FIFO holding DDRAM read words for the tile loader.
//   The head word is visible on head_data whenever empty is low, so the
//   consumer can pop and use the word in the same cycle.
//   Ports:
//     clk, reset   clock, synchronous active-high reset (empties the FIFO)
//     push         write push_data (ignored when full)
//     push_data    WIDTH-bit word to store
//     pop          discard head word (ignored when empty)
//     head_data    current head word
//     empty        no words stored
//     count        number of words stored (0..DEPTH)
// -----------------------------------------------------------------------------
module tile_row_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int           AW     = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_C = (AW+1)'(DEPTH);

   // Asynchronous read so the head word is usable in the pop cycle; the
   // storage therefore maps to distributed RAM rather than block RAM.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push && (count_reg != FULL_C);
   assign do_pop    = pop && (count_reg != '0);
   assign head_data = mem[rd_ptr_reg];
   assign empty     = (count_reg == '0);
   assign count     = count_reg;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/tile_loader.sv
// -----------------------------------------------------------------------------
// tile_loader
//   Loads one TILE_W x TILE_H tile from the DDR3 framebuffer into the tile
//   buffer so shading can blend over existing content. One DDRAM read burst
//   of TILE_W/2 words is issued per tile row; words are queued in a row FIFO,
//   split into two pixels, converted to u0.10 and written one pixel per cycle.
//   Optional feature macro: TILE_LOADER_ALPHA_EN (alpha from byte 3 when
//   defined, otherwise alpha forced to 1.0) -- implemented in tile_pkg.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     start               1-cycle pulse, begin a load (ignored while busy)
//     tile_px, tile_py    tile origin in pixels, sampled on start
//     busy, done          load in progress / 1-cycle completion pulse
//     rd_addr, rd_burstcnt, rd_req, rd_ack, rd_busy, rd_data, rd_valid
//                         ddram_ctrl read port
//     tb_wr_addr, tb_wr_data, tb_wr_en
//                         tile buffer write port, address {row, col}
// -----------------------------------------------------------------------------
module tile_loader
   import tile_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] tile_px,
   input  logic [15:0] tile_py,
   output logic        busy,
   output logic        done,
   output logic [28:0] rd_addr,
   output logic [7:0]  rd_burstcnt,
   output logic        rd_req,
   input  logic        rd_ack,
   input  logic        rd_busy,
   input  logic [63:0] rd_data,
   input  logic        rd_valid,
   output logic [9:0]  tb_wr_addr,
   output logic [63:0] tb_wr_data,
   output logic        tb_wr_en
);

   localparam int ROW_W  = $clog2(TILE_H);
   localparam int COL_W  = $clog2(TILE_W);
   localparam int BEAT_W = $clog2(BURST_LEN) + 1;
   localparam int FAW    = $clog2(FIFO_DEPTH);

   localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(TILE_H - 1);
   localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(TILE_W - 1);
   localparam logic [BEAT_W-1:0] BEATS_C    = BEAT_W'(BURST_LEN);
   localparam logic [FAW:0]      DEPTH_C    = (FAW+1)'(FIFO_DEPTH);
   localparam logic [FAW:0]      BURST_FW_C = (FAW+1)'(BURST_LEN);

   state_t            state_reg;
   logic [ROW_W-1:0]  req_row_reg;
   logic [BEAT_W-1:0] beat_cnt_reg;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_empty;
   logic [63:0]       fifo_head;
   logic [FAW:0]      fifo_count;

   logic              half_pending_reg;
   logic [31:0]       hi_px_reg;
   logic [ROW_W-1:0]  wr_row_reg;
   logic [COL_W-1:0]  wr_col_reg;

   logic              burst_done;
   logic              last_row;
   logic              room_for_burst;

   assign burst_done     = (beat_cnt_reg == BEATS_C);
   assign last_row       = (req_row_reg == ROW_LAST);
   // A new burst is only requested when the whole burst fits, so rd_valid
   // can never arrive while the FIFO is full.
   assign room_for_burst = ((DEPTH_C - fifo_count) >= BURST_FW_C);
   // Beats outside an active burst (idle, after reset, or surplus beats)
   // are dropped.
   assign fifo_push      = rd_valid && (state_reg == S_RECV) && !burst_done;
   assign fifo_pop       = !half_pending_reg && !fifo_empty;

   tile_row_fifo #(
      .WIDTH (64),
      .DEPTH (FIFO_DEPTH)
   ) u_row_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (rd_data),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Request / sequencing FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         rd_req       <= 1'b0;
         rd_addr      <= '0;
         rd_burstcnt  <= '0;
         req_row_reg  <= '0;
         beat_cnt_reg <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  busy        <= 1'b1;
                  rd_addr     <= FB_BASE
                                 + 29'(tile_py) * 29'(STRIDE_WORDS)
                                 + 29'(tile_px >> 1);
                  rd_burstcnt <= 8'(BURST_LEN);
                  req_row_reg <= '0;
                  state_reg   <= S_REQ;
               end
            end
            S_REQ: begin
               if (rd_req) begin
                  // Once raised the request is held regardless of rd_busy.
                  if (rd_ack) begin
                     rd_req       <= 1'b0;
                     beat_cnt_reg <= '0;
                     state_reg    <= S_RECV;
                  end
               end else if (!rd_busy) begin
                  rd_req <= 1'b1;
               end
            end
            S_RECV: begin
               if (burst_done) begin
                  if (last_row) begin
                     state_reg <= S_DRAIN;
                  end else if (room_for_burst) begin
                     // Next row's burst overlaps the drain of this one.
                     req_row_reg <= req_row_reg + 1'b1;
                     rd_addr     <= rd_addr + 29'(STRIDE_WORDS);
                     state_reg   <= S_REQ;
                  end
               end else if (rd_valid) begin
                  beat_cnt_reg <= beat_cnt_reg + 1'b1;
               end
            end
            S_DRAIN: begin
               // The final pixel write is on the outputs this cycle, so done
               // lands in the cycle right after it.
               if (fifo_empty && !half_pending_reg) begin
                  done      <= 1'b1;
                  state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               busy      <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Unpacker: pop a word, write its low pixel, hold the high pixel and
   // write it on the following cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         half_pending_reg <= 1'b0;
         hi_px_reg        <= '0;
         tb_wr_en         <= 1'b0;
         tb_wr_data       <= '0;
         tb_wr_addr       <= '0;
         wr_row_reg       <= '0;
         wr_col_reg       <= '0;
      end else begin
         tb_wr_en <= 1'b0;
         if (half_pending_reg || !fifo_empty) begin
            tb_wr_en   <= 1'b1;
            tb_wr_addr <= {wr_row_reg, wr_col_reg};
            if (wr_col_reg == COL_LAST) begin
               wr_col_reg <= '0;
               wr_row_reg <= wr_row_reg + 1'b1;
            end else begin
               wr_col_reg <= wr_col_reg + 1'b1;
            end
            if (half_pending_reg) begin
               tb_wr_data       <= argb8_to_u010(hi_px_reg);
               half_pending_reg <= 1'b0;
            end else begin
               tb_wr_data       <= argb8_to_u010(fifo_head[31:0]);
               hi_px_reg        <= fifo_head[63:32];
               half_pending_reg <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tile_loader.sv
// -----------------------------------------------------------------------------
// tb_tile_loader
//   Self-checking bench for tile_loader. A DDRAM read model answers row
//   requests and pushes the expected tile buffer writes into a scoreboard
//   queue; a write monitor pops and compares every tb_wr_en beat.
//   Directed steps: reset state, a basic tile with the known pixel word,
//   rd_busy gating with delayed rd_ack, start while busy, reset mid-load.
// -----------------------------------------------------------------------------
module tb_tile_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] tile_px = '0;
   logic [15:0] tile_py = '0;
   logic        busy;
   logic        done;
   logic [28:0] rd_addr;
   logic [7:0]  rd_burstcnt;
   logic        rd_req;
   logic        rd_ack = 1'b0;
   logic        rd_busy = 1'b0;
   logic [63:0] rd_data = '0;
   logic        rd_valid = 1'b0;
   logic [9:0]  tb_wr_addr;
   logic [63:0] tb_wr_data;
   logic        tb_wr_en;

   always #5 clk = ~clk;

   tile_loader dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .tile_px     (tile_px),
      .tile_py     (tile_py),
      .busy        (busy),
      .done        (done),
      .rd_addr     (rd_addr),
      .rd_burstcnt (rd_burstcnt),
      .rd_req      (rd_req),
      .rd_ack      (rd_ack),
      .rd_busy     (rd_busy),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .tb_wr_addr  (tb_wr_addr),
      .tb_wr_data  (tb_wr_data),
      .tb_wr_en    (tb_wr_en)
   );

   typedef struct packed {
      logic [9:0]  addr;
      logic [63:0] data;
   } sb_t;

   sb_t         exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          wr_count = 0;
   int          req_count = 0;
   int          done_count = 0;
   int          tile_wr_base = 0;
   int          req_base = 0;
   int          done_base = 0;
   int          tile_seq = 0;
   int          ack_delay = 0;
   int          reset_hits = 0;
   bit          inject_reset = 1'b0;
   bit          req_prev = 1'b0;
   logic [28:0] exp_base = '0;
   logic [28:0] row0_addr = '0;
   logic [9:0]  w0_addr = '0;
   logic [9:0]  w1_addr = '0;
   logic [63:0] w0_data = '0;
   logic [63:0] w1_data = '0;

`ifdef TILE_LOADER_ALPHA_EN
   localparam logic [15:0] A_PX0 = 16'h0000;
   localparam logic [15:0] A_PX1 = 16'h0202;
`else
   localparam logic [15:0] A_PX0 = 16'h03FF;
   localparam logic [15:0] A_PX1 = 16'h03FF;
`endif

   // Reference conversion: channel byte c becomes c*4 + c/64 in u0.10.
   function automatic logic [63:0] exp_px(input logic [31:0] p);
      logic [15:0] r, g, b, a;
      r = 16'(p[7:0])   * 16'd4 + 16'(p[7:0]   / 8'd64);
      g = 16'(p[15:8])  * 16'd4 + 16'(p[15:8]  / 8'd64);
      b = 16'(p[23:16]) * 16'd4 + 16'(p[23:16] / 8'd64);
`ifdef TILE_LOADER_ALPHA_EN
      a = 16'(p[31:24]) * 16'd4 + 16'(p[31:24] / 8'd64);
`else
      a = 16'h03FF;
`endif
      return {a, b, g, r};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic run_start(input logic [15:0] px, input logic [15:0] py);
      exp_base     = 29'h06000000 + 29'(py) * 29'd320 + 29'(px / 16'd2);
      tile_seq     = tile_seq + 1;
      tile_wr_base = wr_count;
      req_base     = req_count;
      done_base    = done_count;
      tile_px      = px;
      tile_py      = py;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && done_count == done_base; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk({tag, "_done_once"}, 64'(done_count - done_base), 64'd1);
      chk({tag, "_req_count"}, 64'(req_count - req_base), 64'd32);
      chk({tag, "_wr_count"}, 64'(wr_count - tile_wr_base), 64'd1024);
      chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_busy_low"}, 64'(busy), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_rd_req"}, 64'(rd_req), 64'd0);
      chk({tag, "_tb_wr_en"}, 64'(tb_wr_en), 64'd0);
      chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
      chk({tag, "_rd_burstcnt"}, 64'(rd_burstcnt), 64'd0);
      chk({tag, "_tb_wr_addr"}, 64'(tb_wr_addr), 64'd0);
      chk({tag, "_tb_wr_data"}, tb_wr_data, 64'd0);
   endtask

   // DDRAM read model: acks each request after ack_delay cycles, then
   // returns 16 beats on consecutive cycles and queues the expected writes.
   initial begin : ddr_model
      int          row;
      int          seen_seq;
      bit          skip;
      logic [28:0] a0;
      logic [63:0] w;
      sb_t         e;
      row = 0;
      seen_seq = 0;
      forever begin
         @(negedge clk);
         if (rd_req === 1'b1) begin
            if (seen_seq != tile_seq) begin
               seen_seq = tile_seq;
               row = 0;
            end
            a0 = rd_addr;
            for (int i = 0; i < ack_delay; i++) begin
               @(negedge clk);
               chk("req_held", 64'(rd_req), 64'd1);
               chk("req_addr_stable", 64'(rd_addr), 64'(a0));
            end
            chk($sformatf("req_addr_row%0d", row), 64'(rd_addr), 64'(exp_base + 29'(row) * 29'd320));
            chk("req_burstcnt", 64'(rd_burstcnt), 64'd16);
            if (row == 0) row0_addr = rd_addr;
            rd_ack = 1'b1;
            @(negedge clk);
            rd_ack = 1'b0;
            skip = 1'b0;
            for (int b = 0; b < 16; b++) begin
               if (row == 0 && b == 0) w = 64'h80FFFFFF_00102040;
               else w = {$urandom, $urandom};
               rd_valid = 1'b1;
               rd_data  = w;
               if (!skip) begin
                  e.addr = 10'(row * 32 + 2 * b);
                  e.data = exp_px(w[31:0]);
                  exp_q.push_back(e);
                  e.addr = 10'(row * 32 + 2 * b + 1);
                  e.data = exp_px(w[63:32]);
                  exp_q.push_back(e);
               end
               if (inject_reset && row == 10 && b == 7) begin
                  reset_hits = reset_hits + 1;
                  skip = 1'b1;
               end
               @(negedge clk);
            end
            rd_valid = 1'b0;
            rd_data  = '0;
            row = row + 1;
         end
      end
   end

   // Write / request / done monitor, sampled on the falling edge.
   initial begin : wr_monitor
      sb_t e;
      int  n;
      forever begin
         @(negedge clk);
         if (done === 1'b1) done_count = done_count + 1;
         if (rd_req === 1'b1 && !req_prev) req_count = req_count + 1;
         req_prev = (rd_req === 1'b1);
         if (tb_wr_en === 1'b1) begin
            n = wr_count - tile_wr_base;
            wr_count = wr_count + 1;
            if (n == 0) begin w0_addr = tb_wr_addr; w0_data = tb_wr_data; end
            if (n == 1) begin w1_addr = tb_wr_addr; w1_data = tb_wr_data; end
            chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(tb_wr_addr), 64'(e.addr));
               chk("wr_data", tb_wr_data, e.data);
            end
         end
      end
   end

   initial begin : main
      int h0;
      int w0;
      int r0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk_all_zero("rst");
      reset = 1'b0;
      @(negedge clk);

      // Basic tile at (64,32).
      run_start(16'd64, 16'd32);
      wait_done("t1", 4000);
      chk("t1_first_rd_addr", 64'(row0_addr), 64'h06002820);
      chk("t1_w0_addr", 64'(w0_addr), 64'd0);
      chk("t1_w0_data", w0_data, {A_PX0, 16'h0040, 16'h0080, 16'h0101});
      chk("t1_w1_addr", 64'(w1_addr), 64'd1);
      chk("t1_w1_data", w1_data, {A_PX1, 16'h03FF, 16'h03FF, 16'h03FF});

      // rd_busy holds off the request; delayed ack keeps it held.
      rd_busy   = 1'b1;
      ack_delay = 5;
      run_start(16'd0, 16'd100);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t2_req_gated", 64'(rd_req), 64'd0);
      end
      chk("t2_busy_high", 64'(busy), 64'd1);
      rd_busy = 1'b0;
      wait_done("t2", 4000);
      ack_delay = 0;

      // start while busy is ignored.
      run_start(16'd2, 16'd0);
      repeat (50) @(negedge clk);
      tile_px = 16'd640;
      tile_py = 16'd400;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      wait_done("t3", 4000);

      // Reset during row 10, then a fresh full tile.
      inject_reset = 1'b1;
      h0 = reset_hits;
      run_start(16'd64, 16'd0);
      for (int i = 0; i < 3000 && reset_hits == h0; i++) @(negedge clk);
      chk("t4_reached_row10", 64'(reset_hits - h0), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("t4_rst");
      reset = 1'b0;
      inject_reset = 1'b0;
      exp_q.delete();
      w0 = wr_count;
      r0 = req_count;
      repeat (40) @(negedge clk);
      chk("t4_no_writes", 64'(wr_count - w0), 64'd0);
      chk("t4_no_req", 64'(req_count - r0), 64'd0);
      chk("t4_idle", 64'(busy), 64'd0);
      run_start(16'd64, 16'd0);
      wait_done("t4", 4000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
